// File: rtl/lp_ctrl_clk_lane_gen2.sv
// D-PHY clock-lane LP controller (TxClkEsc domain) with internal per-state timers.
// Optional LPCTRL_PROG_TIMING_EN: timing taken from cfg_t_* ports instead of parameters.
module lp_ctrl_clk_lane_gen2 #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned T_LPX     = 5,
  parameter int unsigned T_PREPARE = 4,
  parameter int unsigned T_ZERO    = 30,
  parameter int unsigned T_PRE     = 8,
  parameter int unsigned T_POST    = 10,
  parameter int unsigned T_TRAIL   = 6,
  parameter int unsigned T_WAKEUP  = 100
) (
  input  logic                 TxClkEsc,
  input  logic                 rst,
  input  logic                 Enable,
  input  logic                 ForceTxStopmode,
  input  logic                 TxRequestHS,
  input  logic                 TxUlpsClk,
  input  logic                 TxUlpsExit,
  input  logic                 cont_clk_mode,
`ifdef LPCTRL_PROG_TIMING_EN
  input  logic [CNT_WIDTH-1:0] cfg_t_lpx,
  input  logic [CNT_WIDTH-1:0] cfg_t_prepare,
  input  logic [CNT_WIDTH-1:0] cfg_t_zero,
  input  logic [CNT_WIDTH-1:0] cfg_t_pre,
  input  logic [CNT_WIDTH-1:0] cfg_t_post,
  input  logic [CNT_WIDTH-1:0] cfg_t_trail,
  input  logic [CNT_WIDTH-1:0] cfg_t_wakeup,
`endif
  output logic [1:0]           LP_MODE_SEQ,
  output logic                 HS_EN,
  output logic                 HS_CLK_EN,
  output logic                 TxReadyHS,
  output logic                 Stopstate,
  output logic                 UlpsActiveNot,
  output logic                 ULP_CG_EN,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    StOff      = 4'd0,
    StStop     = 4'd1,
    StHsRqst   = 4'd2,
    StBridge   = 4'd3,
    StHsZero   = 4'd4,
    StHsPre    = 4'd5,
    StHsActive = 4'd6,
    StHsPost   = 4'd7,
    StTrail    = 4'd8,
    StUlpsRqst = 4'd9,
    StUlps     = 4'd10,
    StUlpsExit = 4'd11
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 timer_done;

  logic [1:0] lp_q, lp_d;
  logic       hs_en_q, hs_en_d;
  logic       hs_clk_en_q, hs_clk_en_d;
  logic       ready_q, ready_d;
  logic       stop_q, stop_d;
  logic       ulps_not_q, ulps_not_d;
  logic       cg_en_q, cg_en_d;

  // Counter load values are duration-1 so a state lasts exactly its duration.
  logic [CNT_WIDTH-1:0] ld_lpx, ld_prepare, ld_zero, ld_pre, ld_post, ld_trail, ld_wakeup;

`ifdef LPCTRL_PROG_TIMING_EN
  // A programmed zero behaves like one cycle.
  function automatic logic [CNT_WIDTH-1:0] to_load(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - CNT_WIDTH'(1);
  endfunction

  assign ld_lpx     = to_load(cfg_t_lpx);
  assign ld_prepare = to_load(cfg_t_prepare);
  assign ld_zero    = to_load(cfg_t_zero);
  assign ld_pre     = to_load(cfg_t_pre);
  assign ld_post    = to_load(cfg_t_post);
  assign ld_trail   = to_load(cfg_t_trail);
  assign ld_wakeup  = to_load(cfg_t_wakeup);
`else
  assign ld_lpx     = CNT_WIDTH'(T_LPX - 1);
  assign ld_prepare = CNT_WIDTH'(T_PREPARE - 1);
  assign ld_zero    = CNT_WIDTH'(T_ZERO - 1);
  assign ld_pre     = CNT_WIDTH'(T_PRE - 1);
  assign ld_post    = CNT_WIDTH'(T_POST - 1);
  assign ld_trail   = CNT_WIDTH'(T_TRAIL - 1);
  assign ld_wakeup  = CNT_WIDTH'(T_WAKEUP - 1);
`endif

  assign timer_done = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = timer_done ? '0 : cnt_q - CNT_WIDTH'(1);
    if (!Enable) begin
      state_d = StOff;
      cnt_d   = '0;
    end else if (ForceTxStopmode && (state_q != StOff)) begin
      state_d = StStop;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StOff: state_d = StStop;
        StStop: begin
          if (TxRequestHS) begin
            state_d = StHsRqst;
            cnt_d   = ld_lpx;
          end else if (TxUlpsClk) begin
            state_d = StUlpsRqst;
            cnt_d   = ld_lpx;
          end
        end
        StHsRqst: if (timer_done) begin
          state_d = StBridge;
          cnt_d   = ld_prepare;
        end
        StBridge: if (timer_done) begin
          state_d = StHsZero;
          cnt_d   = ld_zero;
        end
        StHsZero: if (timer_done) begin
          state_d = StHsPre;
          cnt_d   = ld_pre;
        end
        StHsPre: if (timer_done) state_d = StHsActive;
        StHsActive: if (!TxRequestHS && !cont_clk_mode) begin
          state_d = StHsPost;
          cnt_d   = ld_post;
        end
        StHsPost: if (timer_done) begin
          state_d = StTrail;
          cnt_d   = ld_trail;
        end
        StTrail:    if (timer_done) state_d = StStop;
        StUlpsRqst: if (timer_done) state_d = StUlps;
        StUlps: if (TxUlpsExit) begin
          state_d = StUlpsExit;
          cnt_d   = ld_wakeup;
        end
        StUlpsExit: if (timer_done) state_d = StStop;
        default: begin
          state_d = StOff;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    lp_d        = 2'b11;
    hs_en_d     = 1'b0;
    hs_clk_en_d = 1'b0;
    ready_d     = 1'b0;
    stop_d      = 1'b0;
    ulps_not_d  = 1'b1;
    cg_en_d     = 1'b0;
    case (state_d)
      StStop:     stop_d = 1'b1;
      StHsRqst:   lp_d   = 2'b01;
      StBridge:   lp_d   = 2'b00;
      StHsZero: begin
        lp_d    = 2'b00;
        hs_en_d = 1'b1;
      end
      StHsPre, StHsPost: begin
        lp_d        = 2'b00;
        hs_en_d     = 1'b1;
        hs_clk_en_d = 1'b1;
      end
      StHsActive: begin
        lp_d        = 2'b00;
        hs_en_d     = 1'b1;
        hs_clk_en_d = 1'b1;
        ready_d     = 1'b1;
      end
      StTrail: begin
        lp_d    = 2'b00;
        hs_en_d = 1'b1;
      end
      StUlpsRqst: lp_d = 2'b10;
      StUlps: begin
        lp_d       = 2'b00;
        ulps_not_d = 1'b0;
        cg_en_d    = 1'b1;
      end
      StUlpsExit: lp_d = 2'b10;
      default: ;
    endcase
  end

  always_ff @(posedge TxClkEsc) begin
    if (rst) begin
      state_q     <= StOff;
      cnt_q       <= '0;
      lp_q        <= 2'b11;
      hs_en_q     <= 1'b0;
      hs_clk_en_q <= 1'b0;
      ready_q     <= 1'b0;
      stop_q      <= 1'b0;
      ulps_not_q  <= 1'b1;
      cg_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lp_q        <= lp_d;
      hs_en_q     <= hs_en_d;
      hs_clk_en_q <= hs_clk_en_d;
      ready_q     <= ready_d;
      stop_q      <= stop_d;
      ulps_not_q  <= ulps_not_d;
      cg_en_q     <= cg_en_d;
    end
  end

  assign LP_MODE_SEQ   = lp_q;
  assign HS_EN         = hs_en_q;
  assign HS_CLK_EN     = hs_clk_en_q;
  assign TxReadyHS     = ready_q;
  assign Stopstate     = stop_q;
  assign UlpsActiveNot = ulps_not_q;
  assign ULP_CG_EN     = cg_en_q;
  assign state_o       = state_q;

endmodule
